// File: rtl/mcht_pkg.sv
// Shared types and constants for the Manchester transceiver core (mcht_trx_core).
// Optional parity is enabled with `define MCHT_PARITY_EN.
package mcht_pkg;

  typedef enum logic [2:0] {
    TX_IDLE,
    TX_SYNC,
    TX_DATA,
    TX_PAR,
    TX_GUARD
  } tx_state_t;

  typedef enum logic [1:0] {
    RX_IDLE,
    RX_DATA,
    RX_PAR,
    RX_QUIET
  } rx_state_t;

  typedef struct packed {
    tx_state_t tx;
    rx_state_t rx;
  } mcht_dbg_t;

  localparam logic LINE_IDLE = 1'b0;
  localparam logic SYNC_BIT  = 1'b1;

  // Sample points inside one received bit, measured from the bit start.
  function automatic int s1_off(input int osr);
    return osr / 4;
  endfunction

  function automatic int s2_off(input int osr);
    return (3 * osr) / 4;
  endfunction

  // IEEE 802.3 polarity: a 1 is low then high, a 0 is high then low.
  function automatic logic enc_half(input logic b, input logic second);
    return second ? b : ~b;
  endfunction

endpackage

// File: rtl/mcht_rx_dec.sv
// Manchester frame decoder: 2-flop synchroniser, edge-armed framing FSM,
// mid-half sampling with violation detection. Parity check under MCHT_PARITY_EN.
module mcht_rx_dec
  import mcht_pkg::*;
#(
  parameter int DATA_W = 8,
  parameter int OSR    = 8
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              rx_line,
  output logic [DATA_W-1:0] rx_data,
  output logic              rx_valid,
  output logic              rx_err,
  output rx_state_t         rx_state
);

  localparam int CW = $clog2(2 * OSR);
  localparam int QW = $clog2(OSR);
  localparam int BW = (DATA_W > 1) ? $clog2(DATA_W) : 1;

  // rx_cnt counts cycles from the SYNC edge for bit 0 and then wraps per bit,
  // so every bit occupies BIT_START..BIT_END and the sample points are fixed.
  localparam logic [CW-1:0] BIT_START = CW'(OSR / 2);
  localparam logic [CW-1:0] BIT_END   = CW'(OSR / 2 + OSR - 1);
  localparam logic [CW-1:0] S1_AT     = CW'(OSR / 2 + s1_off(OSR));
  localparam logic [CW-1:0] S2_AT     = CW'(OSR / 2 + s2_off(OSR));
  localparam logic [BW-1:0] LAST_BIT  = BW'(DATA_W - 1);
  localparam logic [QW-1:0] QUIET_END = QW'(OSR - 1);

  logic              s_meta, s_sync, s_prev;
  logic              rise;
  logic [CW-1:0]     rx_cnt;
  logic [BW-1:0]     rx_bit;
  logic [QW-1:0]     rx_qcnt;
  logic              rx_s1;
  logic [DATA_W-1:0] rx_sh, data_nxt;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      s_meta <= 1'b0;
      s_sync <= 1'b0;
      s_prev <= 1'b0;
    end else begin
      s_meta <= rx_line;
      s_sync <= s_meta;
      s_prev <= s_sync;
    end
  end

  assign rise = s_sync & ~s_prev;

  always_comb begin
    data_nxt = rx_sh >> 1;
    data_nxt[DATA_W-1] = s_sync;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rx_state <= RX_IDLE;
      rx_cnt   <= '0;
      rx_bit   <= '0;
      rx_qcnt  <= '0;
      rx_s1    <= 1'b0;
      rx_sh    <= '0;
      rx_data  <= '0;
      rx_valid <= 1'b0;
      rx_err   <= 1'b0;
    end else begin
      rx_valid <= 1'b0;
      rx_err   <= 1'b0;
      unique case (rx_state)
        RX_IDLE: begin
          if (rise) begin
            rx_state <= RX_DATA;
            rx_cnt   <= CW'(1);
            rx_bit   <= '0;
          end
        end
        RX_DATA, RX_PAR: begin
          rx_cnt <= (rx_cnt == BIT_END) ? BIT_START : rx_cnt + CW'(1);
          if (rx_cnt == S1_AT) rx_s1 <= s_sync;
          if (rx_cnt == S2_AT) begin
            if (rx_s1 == s_sync) begin
              rx_err   <= 1'b1;
              rx_state <= RX_QUIET;
              rx_qcnt  <= '0;
            end else if (rx_state == RX_DATA) begin
              rx_sh <= data_nxt;
              if (rx_bit == LAST_BIT) begin
`ifdef MCHT_PARITY_EN
                rx_state <= RX_PAR;
`else
                rx_data  <= data_nxt;
                rx_valid <= 1'b1;
                rx_state <= RX_IDLE;
`endif
              end else begin
                rx_bit <= rx_bit + BW'(1);
              end
            end else if ((^rx_sh) != s_sync) begin
              rx_err   <= 1'b1;
              rx_state <= RX_QUIET;
              rx_qcnt  <= '0;
            end else begin
              rx_data  <= rx_sh;
              rx_valid <= 1'b1;
              rx_state <= RX_IDLE;
            end
          end
        end
        RX_QUIET: begin
          if (s_sync) rx_qcnt <= '0;
          else if (rx_qcnt == QUIET_END) rx_state <= RX_IDLE;
          else rx_qcnt <= rx_qcnt + QW'(1);
        end
        default: rx_state <= RX_IDLE;
      endcase
    end
  end

endmodule

// File: rtl/mcht_trx_core.sv
// Parametrised Manchester transceiver: valid/ready TX framer plus mcht_rx_dec.
// Build option: `define MCHT_PARITY_EN adds an even-parity bit after the data.
module mcht_trx_core
  import mcht_pkg::*;
#(
  parameter int DATA_W = 8,
  parameter int OSR    = 8
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic [DATA_W-1:0] tx_data,
  input  logic              tx_valid,
  output logic              tx_ready,
  output logic              tx_line,
  output logic              tx_busy,
  input  logic              rx_line,
  output logic [DATA_W-1:0] rx_data,
  output logic              rx_valid,
  output logic              rx_err,
  output mcht_dbg_t         dbg_state
);

  // Handshake: a payload transfers on every clk edge where tx_valid && tx_ready;
  // tx_data is sampled only on that edge and ignored at all other times.

  localparam int CW = $clog2(OSR);
  localparam int BW = (DATA_W > 1) ? $clog2(DATA_W) : 1;
  localparam logic [CW-1:0] HALF_M1  = CW'(OSR / 2 - 1);
  localparam logic [CW-1:0] PRE_LAST = CW'(OSR - 2);
  localparam logic [CW-1:0] LAST     = CW'(OSR - 1);
  localparam logic [BW-1:0] LAST_BIT = BW'(DATA_W - 1);

  tx_state_t         tx_state;
  rx_state_t         rx_state;
  logic [CW-1:0]     tx_cnt;
  logic [BW-1:0]     tx_bit;
  logic [DATA_W-1:0] tx_sh, tx_sh_nxt;
  logic              tx_hs;
`ifdef MCHT_PARITY_EN
  logic              tx_par;
`endif

  assign tx_hs     = tx_valid && tx_ready;
  assign tx_sh_nxt = tx_sh >> 1;
  assign dbg_state = '{tx: tx_state, rx: rx_state};

  // tx_line is loaded one cycle ahead: each branch writes the half-bit level
  // that the next cycle must show.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      tx_state <= TX_IDLE;
      tx_cnt   <= '0;
      tx_bit   <= '0;
      tx_sh    <= '0;
      tx_line  <= LINE_IDLE;
      tx_ready <= 1'b1;
      tx_busy  <= 1'b0;
`ifdef MCHT_PARITY_EN
      tx_par   <= 1'b0;
`endif
    end else if (tx_hs) begin
      tx_state <= TX_SYNC;
      tx_cnt   <= '0;
      tx_sh    <= tx_data;
      tx_line  <= enc_half(SYNC_BIT, 1'b0);
      tx_ready <= 1'b0;
      tx_busy  <= 1'b1;
`ifdef MCHT_PARITY_EN
      tx_par   <= ^tx_data;
`endif
    end else begin
      tx_cnt <= (tx_cnt == LAST) ? '0 : tx_cnt + CW'(1);
      unique case (tx_state)
        TX_IDLE: tx_cnt <= '0;
        TX_SYNC: begin
          if (tx_cnt == HALF_M1) tx_line <= enc_half(SYNC_BIT, 1'b1);
          if (tx_cnt == LAST) begin
            tx_state <= TX_DATA;
            tx_bit   <= '0;
            tx_line  <= enc_half(tx_sh[0], 1'b0);
          end
        end
        TX_DATA: begin
          if (tx_cnt == HALF_M1) tx_line <= enc_half(tx_sh[0], 1'b1);
          if (tx_cnt == LAST) begin
            if (tx_bit == LAST_BIT) begin
`ifdef MCHT_PARITY_EN
              tx_state <= TX_PAR;
              tx_line  <= enc_half(tx_par, 1'b0);
`else
              tx_state <= TX_GUARD;
              tx_line  <= LINE_IDLE;
`endif
            end else begin
              tx_bit  <= tx_bit + BW'(1);
              tx_sh   <= tx_sh_nxt;
              tx_line <= enc_half(tx_sh_nxt[0], 1'b0);
            end
          end
        end
`ifdef MCHT_PARITY_EN
        TX_PAR: begin
          if (tx_cnt == HALF_M1) tx_line <= enc_half(tx_par, 1'b1);
          if (tx_cnt == LAST) begin
            tx_state <= TX_GUARD;
            tx_line  <= LINE_IDLE;
          end
        end
`endif
        TX_GUARD: begin
          // Ready opens for the final guard cycle so a waiting payload is taken
          // exactly as the guard ends, giving back-to-back frames with no gap.
          if (tx_cnt == PRE_LAST) tx_ready <= 1'b1;
          if (tx_cnt == LAST) begin
            tx_state <= TX_IDLE;
            tx_busy  <= 1'b0;
          end
        end
        default: begin
          tx_state <= TX_IDLE;
          tx_line  <= LINE_IDLE;
          tx_ready <= 1'b1;
          tx_busy  <= 1'b0;
        end
      endcase
    end
  end

  mcht_rx_dec #(
    .DATA_W(DATA_W),
    .OSR   (OSR)
  ) u_rx_dec (
    .clk     (clk),
    .rst_n   (rst_n),
    .rx_line (rx_line),
    .rx_data (rx_data),
    .rx_valid(rx_valid),
    .rx_err  (rx_err),
    .rx_state(rx_state)
  );

endmodule

// File: tb/tb_mcht_trx_core.sv
// Self-checking bench for mcht_trx_core: loopback and bench-driven Manchester frames,
// scoreboard queue of expected payloads, error and reset scenarios.
module tb_mcht_trx_core;
  import mcht_pkg::*;

  localparam int DW    = 8;
  localparam int OSR_P = 8;
`ifdef MCHT_PARITY_EN
  localparam int PAR_B = 1;
`else
  localparam int PAR_B = 0;
`endif
  localparam int FRAME = (DW + 2 + PAR_B) * OSR_P;

  // clock / reset
  logic clk = 1'b0;
  logic rst_n;
  always #5 clk = ~clk;

  logic [DW-1:0] tx_data;
  logic          tx_valid, tx_ready, tx_line, tx_busy;
  logic          rx_line, rx_valid, rx_err;
  logic [DW-1:0] rx_data;
  mcht_dbg_t     dbg_state;
  logic          loop_en, rx_drv;

  assign rx_line = loop_en ? tx_line : rx_drv;

  mcht_trx_core #(.DATA_W(DW), .OSR(OSR_P)) dut (
    .clk      (clk),
    .rst_n    (rst_n),
    .tx_data  (tx_data),
    .tx_valid (tx_valid),
    .tx_ready (tx_ready),
    .tx_line  (tx_line),
    .tx_busy  (tx_busy),
    .rx_line  (rx_line),
    .rx_data  (rx_data),
    .rx_valid (rx_valid),
    .rx_err   (rx_err),
    .dbg_state(dbg_state)
  );

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  // scoreboard
  logic [DW-1:0] exp_q[$];
  logic [DW-1:0] exp_d;
  logic [DW-1:0] last_good = '0;
  int err_exp = 0;
  int n_valid = 0;
  int n_checks = 0;
  int n_pass = 0;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got 0x%0h expected 0x%0h (t=%0t)", tag, got, exp, $time);
  endtask

  always @(negedge clk) begin
    if (rst_n) begin
      if (rx_valid && rx_err) check("valid_err_overlap", 32'(rx_err), 32'd0);
      if (rx_valid) begin
        n_valid++;
        if (exp_q.size() == 0) check("rx_valid_unexpected", 32'(rx_valid), 32'd0);
        else begin
          exp_d = exp_q.pop_front();
          check("rx_data", 32'(rx_data), 32'(exp_d));
          last_good = exp_d;
        end
      end
      if (rx_err) begin
        if (err_exp == 0) check("rx_err_unexpected", 32'(rx_err), 32'd0);
        else begin
          err_exp--;
          check("rx_err_data_held", 32'(rx_data), 32'(last_good));
        end
      end
    end
  end

  // driver tasks
  task automatic do_hs(input logic [DW-1:0] d, output int hs_cyc);
    int n = 0;
    tx_data  = d;
    tx_valid = 1'b1;
    while (!tx_ready && n < 500) begin
      @(negedge clk);
      n++;
    end
    if (!tx_ready) check("hs_timeout", 32'(tx_ready), 32'd1);
    hs_cyc = cyc;
    exp_q.push_back(d);
    @(negedge clk);
  endtask

  task automatic wait_rx_done();
    int n = 0;
    while ((exp_q.size() != 0 || err_exp != 0) && n < 2000) begin
      @(negedge clk);
      n++;
    end
    check("rx_done_pending", 32'(exp_q.size() + err_exp), 32'd0);
    repeat (OSR_P * 2) @(negedge clk);
  endtask

  task automatic drive_bit(input logic b);
    rx_drv = ~b;
    repeat (OSR_P / 2) @(negedge clk);
    rx_drv = b;
    repeat (OSR_P / 2) @(negedge clk);
  endtask

  task automatic drive_rx_frame(input logic [DW-1:0] d, input logic flip);
    if (flip && PAR_B == 1) err_exp++;
    else exp_q.push_back(d);
    drive_bit(1'b1);
    for (int i = 0; i < DW; i++) drive_bit(d[i]);
`ifdef MCHT_PARITY_EN
    drive_bit((^d) ^ flip);
`endif
    rx_drv = 1'b0;
    repeat (2 * OSR_P) @(negedge clk);
  endtask

  task automatic check_reset_outputs(input string pfx);
    check({pfx, "_tx_line"},  32'(tx_line),  32'd0);
    check({pfx, "_tx_ready"}, 32'(tx_ready), 32'd1);
    check({pfx, "_tx_busy"},  32'(tx_busy),  32'd0);
    check({pfx, "_rx_data"},  32'(rx_data),  32'd0);
    check({pfx, "_rx_valid"}, 32'(rx_valid), 32'd0);
    check({pfx, "_rx_err"},   32'(rx_err),   32'd0);
  endtask

  initial begin
    int h0, h1, k, hi, nr, v0;
    rst_n = 1'b0;
    tx_valid = 1'b0;
    tx_data = '0;
    loop_en = 1'b1;
    rx_drv = 1'b0;
    repeat (3) @(negedge clk);
    check_reset_outputs("reset");
    check("reset_dbg_tx", 32'(dbg_state.tx), 32'(TX_IDLE));
    check("reset_dbg_rx", 32'(dbg_state.rx), 32'(RX_IDLE));
    rst_n = 1'b1;

    // idle line
    hi = 0;
    nr = 0;
    repeat (100) begin
      @(negedge clk);
      if (tx_line) hi++;
      if (!tx_ready) nr++;
    end
    check("idle_tx_line_high_cycles", 32'(hi), 32'd0);
    check("idle_tx_ready_low_cycles", 32'(nr), 32'd0);

    // single frame in loopback, plus ignored tx_valid while busy
    v0 = n_valid;
    do_hs(8'hA5, h0);
    tx_valid = 1'b0;
    tx_data = 8'h00;
    check("a5_tx_busy", 32'(tx_busy), 32'd1);
    check("a5_tx_ready", 32'(tx_ready), 32'd0);
    k = 0;
    while (!tx_line && k < 20) begin
      @(negedge clk);
      k++;
    end
    check("sync_rise_delay", 32'(k), 32'(OSR_P / 2));
    repeat (16) @(negedge clk);
    tx_data = 8'h11;
    tx_valid = 1'b1;
    repeat (4) @(negedge clk);
    tx_valid = 1'b0;
    wait_rx_done();
    check("a5_valid_count", 32'(n_valid - v0), 32'd1);
    k = 0;
    while (tx_busy && k < 200) begin
      @(negedge clk);
      k++;
    end
    check("a5_tx_busy_end", 32'(tx_busy), 32'd0);
    check("a5_tx_ready_end", 32'(tx_ready), 32'd1);

    // back-to-back with tx_valid held
    do_hs(8'h00, h0);
    do_hs(8'hFF, h1);
    tx_valid = 1'b0;
    check("b2b_frame_period", 32'(h1 - h0), 32'(FRAME));
    wait_rx_done();

    // random payloads
    for (int i = 0; i < 3; i++) begin
      do_hs(DW'($urandom_range(0, 255)), h0);
      tx_valid = 1'b0;
    end
    wait_rx_done();

    // violation: SYNC edge then line stuck high for two bit times
    loop_en = 1'b0;
    rx_drv = 1'b0;
    repeat (12) @(negedge clk);
    v0 = n_valid;
    err_exp = 1;
    rx_drv = 1'b1;
    repeat (2 * OSR_P) @(negedge clk);
    rx_drv = 1'b0;
    repeat (12) @(negedge clk);
    wait_rx_done();
    check("viol_no_valid", 32'(n_valid - v0), 32'd0);
    drive_rx_frame(8'h3C, 1'b0);
    wait_rx_done();

`ifdef MCHT_PARITY_EN
    drive_rx_frame(8'h07, 1'b1);
    wait_rx_done();
    check("par_err_data_held", 32'(rx_data), 32'h3C);
    drive_rx_frame(8'h07, 1'b0);
    wait_rx_done();
`endif

    // reset mid-frame on both sides
    loop_en = 1'b1;
    do_hs(8'h33, h0);
    tx_valid = 1'b0;
    repeat (30) @(negedge clk);
    check("mid_tx_busy", 32'(tx_busy), 32'd1);
    rst_n = 1'b0;
    exp_q.delete();
    last_good = '0;
    #1;
    check_reset_outputs("midrst");
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    do_hs(8'h5A, h0);
    tx_valid = 1'b0;
    wait_rx_done();
    check("post_reset_rx_data", 32'(rx_data), 32'h5A);

    check("final_pending", 32'(exp_q.size() + err_exp), 32'd0);
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
